seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the driving end of the serial bit-sequence detectors (din/detected).

---
 rtl/seq_tx_pkg.sv | 20 ++
 rtl/seq_pattern_tx_if.sv | 26 ++
 rtl/seq_tx_shreg.sv | 49 ++++
 rtl/seq_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// State encoding, length-width helper and default sizing.
package seq_tx_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAR,
    ST_GAP
  } state_e;

  // Bits needed to hold a length in 0..width inclusive.
  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Pattern-in handshake plus serial-out bundle for seq_pattern_tx.
// master = pattern source / serial sink, slave = the transmitter.
interface seq_pattern_tx_if #(
  parameter int WIDTH = seq_tx_pkg::DEF_WIDTH
) ();
  localparam int LEN_W = seq_tx_pkg::len_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pattern_data;
  logic [LEN_W-1:0] pattern_len;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, pattern_data, pattern_len,
    input  in_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  in_valid, pattern_data, pattern_len,
    output in_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-aligned shift register with remaining-bit down-counter.
// head_bit is the first bit of the word being loaded; cur_bit/last describe the word in flight.
module seq_tx_shreg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             head_bit,
  output logic             cur_bit,
  output logic             last
);
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  // Left-align so the first bit to send always sits at the MSB.
  assign aligned  = data << (LEN_W'(WIDTH) - len);
  assign head_bit = aligned[WIDTH-1];
  assign cur_bit  = sr_q[WIDTH-1];
  assign last     = (cnt_q == '0);

  // The head bit leaves on load, so the register holds only the bits still to come.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = aligned << 1;
      cnt_d = len - LEN_W'(1);
    end else if (shift) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word+length, sends it MSB-first one bit per clock, then idles GAP_CYCLES.
// Optional even-parity trailer bit when SEQ_PATTERN_TX_PARITY_EN is defined.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);
  localparam int LEN_W = len_w(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Where a finished pattern goes: straight to IDLE with done, or into the gap.
  localparam state_e          END_ST   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
  localparam logic            END_DONE = (GAP_CYCLES == 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             accept;
  logic [LEN_W-1:0] len_eff;
  logic             load, shift;
  logic             head_bit, cur_bit, last;

  assign accept  = bus.in_valid && in_ready_q;
  assign len_eff = (bus.pattern_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.pattern_len;

  seq_tx_shreg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .data     (bus.pattern_data),
    .len      (len_eff),
    .head_bit (head_bit),
    .cur_bit  (cur_bit),
    .last     (last)
  );

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (len_eff != '0) begin
            state_d      = ST_SHIFT;
            load         = 1'b1;
            dout_d       = head_bit;
            dout_valid_d = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_d        = head_bit;
`endif
          end else begin
            state_d   = END_ST;
            done_d    = END_DONE;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      ST_SHIFT: begin
        if (!last) begin
          shift        = 1'b1;
          dout_d       = cur_bit;
          dout_valid_d = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_d        = par_q ^ cur_bit;
`endif
        end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          state_d      = ST_PAR;
          dout_d       = par_q;
          dout_valid_d = 1'b1;
`else
          state_d   = END_ST;
          done_d    = END_DONE;
          gap_cnt_d = GAP_LOAD;
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      ST_PAR: begin
        state_d   = END_ST;
        done_d    = END_DONE;
        gap_cnt_d = GAP_LOAD;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in_ready_q   <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      in_ready_q   <= in_ready_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.in_ready   = in_ready_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (WIDTH=8, GAP_CYCLES=1); expected bit streams are hand-written strings.
// Parity trailer characters are appended only when SEQ_PATTERN_TX_PARITY_EN is defined.
module tb_seq_pattern_tx;
  localparam int WIDTH = 8;
  localparam int GAP   = 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  seq_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

  seq_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] l);
    bus.in_valid     = v;
    bus.pattern_data = d;
    bus.pattern_len  = l;
  endtask

  function automatic string wp(input string b, input string p);
    return PAR_EN ? {b, p} : b;
  endfunction

  // One check set per on-wire bit, advancing a cycle after each.
  task automatic check_bits(input string tag, input string bits);
    byte c;
    for (int i = 0; i < bits.len(); i++) begin
      c = bits[i];
      check($sformatf("%s_vld%0d", tag, i), 32'(bus.dout_valid), 32'd1);
      check($sformatf("%s_bit%0d", tag, i), 32'(bus.dout), (c == 8'h31) ? 32'd1 : 32'd0);
      check($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
      check($sformatf("%s_rdy%0d", tag, i), 32'(bus.in_ready), 32'd0);
      tick;
    end
  endtask

  // Gap cycles, then the done cycle (left in place, no trailing tick).
  task automatic check_gap_done(input string tag);
    for (int g = 0; g < GAP; g++) begin
      check($sformatf("%s_gap_vld%0d", tag, g), 32'(bus.dout_valid), 32'd0);
      check($sformatf("%s_gap_dout%0d", tag, g), 32'(bus.dout), 32'd0);
      check($sformatf("%s_gap_busy%0d", tag, g), 32'(bus.busy), 32'd1);
      check($sformatf("%s_gap_done%0d", tag, g), 32'(bus.done), 32'd0);
      tick;
    end
    check({tag, "_done"},     32'(bus.done),       32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy),      32'd0);
    check({tag, "_done_rdy"},  32'(bus.in_ready),  32'd1);
    check({tag, "_done_vld"},  32'(bus.dout_valid), 32'd0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 4'd0);
    reset = 1'b1;
    tick;
    tick;
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    tick;
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_vld", 32'(bus.dout_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 7-bit pattern; inputs scrambled right after accept must not matter.
    drive(1'b1, 8'b0101_101, 4'd7);
    tick;
    drive(1'b0, 8'hFF, 4'd3);
    check_bits("t2", wp("0101101", "0"));
    check_gap_done("t2");
    tick;
    check("t2_done_pulse_end", 32'(bus.done), 32'd0);

    // Zero length: no data bits, done after GAP+1 cycles.
    drive(1'b1, 8'hFF, 4'd0);
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_gap_done("t3a");
    tick;

    // Over-long length clamps to WIDTH.
    drive(1'b1, 8'hA5, 4'd12);
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_bits("t3b", wp("10100101", "0"));
    check_gap_done("t3b");
    tick;

    // in_valid held through the word: second word waits for the done cycle.
    drive(1'b1, 8'hC3, 4'd8);
    tick;
    drive(1'b1, 8'h3C, 4'd4);
    check_bits("t4a", wp("11000011", "0"));
    check_gap_done("t4a");
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_bits("t4b", wp("1100", "0"));
    check_gap_done("t4b");
    tick;

    // Reset in the middle of an 8-bit word.
    drive(1'b1, 8'b1110_0101, 4'd8);
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_bits("t5", "111");
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t5_rst_dout", 32'(bus.dout), 32'd0);
    check("t5_rst_vld", 32'(bus.dout_valid), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_done", 32'(bus.done), 32'd0);
    tick;
    check("t5_post_done", 32'(bus.done), 32'd0);
    check("t5_post_rdy", 32'(bus.in_ready), 32'd1);
    check("t5_post_vld", 32'(bus.dout_valid), 32'd0);
    drive(1'b1, 8'h02, 4'd2);
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_bits("t5b", wp("10", "1"));
    check_gap_done("t5b");
    tick;

    // Parity-sensitive pair: even and odd count of ones.
    drive(1'b1, 8'b1011_0001, 4'd8);
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_bits("t6a", wp("10110001", "0"));
    check_gap_done("t6a");
    tick;
    drive(1'b1, 8'b1011_0011, 4'd8);
    tick;
    drive(1'b0, 8'h00, 4'd0);
    check_bits("t6b", wp("10110011", "1"));
    check_gap_done("t6b");
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
